pdec_accum: RTL and testbench

PDEC_ACCUM -- requirements
Module: pdec_accum

---
 rtl/pdec_pkg.sv | 26 ++
 rtl/pdec_accum_dec3to8.sv | 15 +
 rtl/pdec_accum.sv | 117 +++++++++++
 tb/tb_pdec_accum.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdec_pkg.sv
// Shared constants, state encoding and popcount helper for the
// priority-decode accumulator.
package pdec_pkg;

  localparam int LANES   = 8;
  localparam int CODE_W  = 3;
  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  function automatic logic [COUNT_W-1:0] popcount(
    input logic [LANES-1:0] v
  );
    logic [COUNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + COUNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pdec_accum_dec3to8.sv
// 3-bit lane code to 8-bit one-hot decoder.
// Purely combinational; used on the accept path of pdec_accum.
module pdec_dec3to8
  import pdec_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [LANES-1:0]  onehot
);

  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/pdec_accum.sv
// Frame accumulator: ORs decoded lane codes into a request mask.
// Optional descending-order check under PDEC_ORDER_CHECK_EN.
module pdec_accum
  import pdec_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CODE_W-1:0]  in_code,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [LANES-1:0]   onehot,
  output logic [LANES-1:0]   out_mask,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err
);

  state_t           state;
  state_t           state_nx;
  logic [LANES-1:0] acc;
  logic [LANES-1:0] dec;
  logic [LANES-1:0] merged;
  logic             accept;
  logic             hs;

  pdec_dec3to8 u_dec (
    .code   (in_code),
    .onehot (dec)
  );

  assign in_ready = (state != DONE);
  assign accept   = in_valid & in_ready;
  assign hs       = (state == DONE) & out_ready;
  assign merged   = acc | dec;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE,
      COLLECT: begin
        if (accept) begin
          state_nx = in_last ? DONE : COLLECT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      onehot    <= '0;
      out_mask  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        acc    <= merged;
        onehot <= dec;
        if (in_last) begin
          out_mask  <= merged;
          out_count <= popcount(merged);
          out_valid <= 1'b1;
        end
      end
      if (hs) begin
        acc       <= '0;
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PDEC_ORDER_CHECK_EN
  logic [CODE_W-1:0] prev;
  logic              sticky;
  logic              err_q;
  logic              viol;

  // The first code of a frame has no predecessor to compare against.
  assign viol = (state == COLLECT) && (in_code >= prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev   <= '0;
      sticky <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        prev <= in_code;
        if (in_last) begin
          err_q  <= sticky | viol;
          sticky <= 1'b0;
        end else begin
          sticky <= sticky | viol;
        end
      end
      if (hs) begin
        err_q <= 1'b0;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pdec_accum.sv
// Scoreboard bench for pdec_accum: a frame model pushes expected
// results on accept; scenario tasks pop and compare on output.
module tb_pdec_accum;

  typedef struct packed {
    logic [7:0] mask;
    logic [3:0] cnt;
    logic       err;
  } res_t;

`ifdef PDEC_ORDER_CHECK_EN
  localparam bit ORDER_EN = 1'b1;
`else
  localparam bit ORDER_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] in_code = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic [7:0] onehot;
  logic [7:0] out_mask;
  logic [3:0] out_count;
  logic       out_valid;
  logic       err;

  int checks = 0;
  int errors = 0;

  res_t       sb[$];
  logic [7:0] m_acc = '0;
  logic [2:0] m_prev = '0;
  logic       m_first = 1'b1;
  logic       m_err = 1'b0;

  pdec_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_code   (in_code),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .onehot    (onehot),
    .out_mask  (out_mask),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_acc   = '0;
    m_prev  = '0;
    m_first = 1'b1;
    m_err   = 1'b0;
  endtask

  task automatic model_accept(input logic [2:0] code, input logic last);
    res_t r;
    if (!m_first && code >= m_prev) m_err = 1'b1;
    m_acc   = m_acc | (8'd1 << code);
    m_prev  = code;
    m_first = 1'b0;
    if (last) begin
      r.mask = m_acc;
      r.cnt  = 4'($countones(m_acc));
      r.err  = ORDER_EN ? m_err : 1'b0;
      sb.push_back(r);
      model_clear();
    end
  endtask

  task automatic send(input logic [2:0] code, input logic last);
    int n = 0;
    @(negedge clk);
    in_code  = code;
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    model_accept(code, last);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect(output res_t got, output bit to);
    int n = 0;
    to = 1'b0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) to = 1'b1;
    got = {out_mask, out_count, err};
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({in_ready, out_valid, err} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: rdy/vld/err=%b required 100",
               {in_ready, out_valid, err});
    end
    checks++;
    if ({onehot, out_mask, out_count} !== 20'd0) begin
      errors++;
      $display("FAIL reset_data: onehot=%h mask=%h cnt=%0d required 0",
               onehot, out_mask, out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    res_t got, exp;
    bit   to;
    send(3'd7, 1'b0);
    checks++;
    if (onehot !== 8'h80) begin
      errors++;
      $display("FAIL basic_onehot7: got %h required 80", onehot);
    end
    send(3'd3, 1'b0);
    send(3'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: out_valid=%b required 1", out_valid);
    end
    collect(got, to);
    exp = sb.pop_front();
    checks++;
    if (to || got !== exp || got.mask !== 8'b10001001) begin
      errors++;
      $display("FAIL basic_result: got %h/%0d/%b to=%0d required %h/%0d/%b",
               got.mask, got.cnt, got.err, to, exp.mask, exp.cnt, exp.err);
    end
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL basic_release: vld/rdy=%b required 01",
               {out_valid, in_ready});
    end
  endtask

  task automatic test_hold();
    res_t got, exp;
    bit   to;
    send(3'd5, 1'b1);
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_mask, out_count} !== {2'b01, 8'h20, 4'd1}) begin
        errors++;
        $display("FAIL hold_stable: rdy=%b vld=%b mask=%h cnt=%0d required 0 1 20 1",
                 in_ready, out_valid, out_mask, out_count);
      end
    end
    collect(got, to);
    exp = sb.pop_front();
    checks++;
    if (to || got !== exp) begin
      errors++;
      $display("FAIL hold_result: got %h/%0d/%b to=%0d required %h/%0d/%b",
               got.mask, got.cnt, got.err, to, exp.mask, exp.cnt, exp.err);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_idle: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_dup();
    res_t got, exp;
    bit   to;
    for (int i = 0; i < 3; i++) begin
      send(3'd2, i == 2);
      checks++;
      if (onehot !== 8'h04) begin
        errors++;
        $display("FAIL dup_onehot%0d: got %h required 04", i, onehot);
      end
    end
    collect(got, to);
    exp = sb.pop_front();
    checks++;
    if (to || got !== exp || got.cnt !== 4'd1) begin
      errors++;
      $display("FAIL dup_result: got %h/%0d/%b to=%0d required %h/%0d/%b",
               got.mask, got.cnt, got.err, to, exp.mask, exp.cnt, exp.err);
    end
  endtask

  task automatic test_order();
    res_t got, exp;
    bit   to;
    send(3'd1, 1'b0);
    send(3'd4, 1'b1);
    collect(got, to);
    exp = sb.pop_front();
    checks++;
    if (to || got !== exp) begin
      errors++;
      $display("FAIL order_bad: got %h/%0d/%b to=%0d required %h/%0d/%b",
               got.mask, got.cnt, got.err, to, exp.mask, exp.cnt, exp.err);
    end
    send(3'd6, 1'b0);
    send(3'd2, 1'b1);
    collect(got, to);
    exp = sb.pop_front();
    checks++;
    if (to || got !== exp || got.err !== 1'b0) begin
      errors++;
      $display("FAIL order_good: got %h/%0d/%b to=%0d required %h/%0d/%b",
               got.mask, got.cnt, got.err, to, exp.mask, exp.cnt, exp.err);
    end
  endtask

  task automatic test_reset_mid();
    res_t got, exp;
    bit   to;
    send(3'd6, 1'b0);
    send(3'd1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({in_ready, out_valid, onehot} !== {2'b10, 8'h00}) begin
      errors++;
      $display("FAIL midreset_state: rdy=%b vld=%b onehot=%h required 1 0 00",
               in_ready, out_valid, onehot);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(3'd0, 1'b1);
    checks++;
    if (onehot !== 8'h01) begin
      errors++;
      $display("FAIL midreset_onehot: got %h required 01", onehot);
    end
    collect(got, to);
    exp = sb.pop_front();
    checks++;
    if (to || got !== exp || got.mask !== 8'h01) begin
      errors++;
      $display("FAIL midreset_result: got %h/%0d/%b to=%0d required %h/%0d/%b",
               got.mask, got.cnt, got.err, to, exp.mask, exp.cnt, exp.err);
    end
  endtask

  task automatic test_back_to_back();
    res_t got, exp;
    bit   to;
    send(3'd4, 1'b1);
    @(negedge clk);
    in_code  = 3'd3;
    in_valid = 1'b1;
    in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({in_ready, onehot, out_mask} !== {1'b0, 8'h10, 8'h10}) begin
        errors++;
        $display("FAIL b2b_blocked: rdy=%b onehot=%h mask=%h required 0 10 10",
                 in_ready, onehot, out_mask);
      end
    end
    got = {out_mask, out_count, err};
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp = sb.pop_front();
    checks++;
    if (got !== exp || {out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_first: got %h/%0d vld=%b rdy=%b required %h/%0d 0 1",
               got.mask, got.cnt, out_valid, in_ready, exp.mask, exp.cnt);
    end
    @(posedge clk);
    model_accept(3'd3, 1'b1);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    collect(got, to);
    exp = sb.pop_front();
    checks++;
    if (to || got !== exp || got.mask !== 8'h08) begin
      errors++;
      $display("FAIL b2b_fresh: got %h/%0d/%b to=%0d required %h/%0d/%b",
               got.mask, got.cnt, got.err, to, exp.mask, exp.cnt, exp.err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_dup();
    test_order();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d left required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
